// File: rtl/spike_encoder.sv
// Time-to-first-spike encoder: latches an intensity vector, then emits one
// spike per nonzero channel over a MAX+1 cycle window, followed by a short gap.
module spike_encoder #(
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned VBITS   = 3,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH-1:0][VBITS-1:0] values,
    output logic [NUM_CH-1:0]            spikes_out,
    output logic [VBITS-1:0]             time_out,
    output logic                         busy,
    output logic                         window_done,
    output logic [$clog2(NUM_CH+1)-1:0]  spike_cnt
);

    localparam int unsigned CW = $clog2(NUM_CH + 1);
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [VBITS-1:0] T_MAX    = '1;
    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENCODE,
        S_GAP
    } state_e;

    state_e                       state_q, state_d;
    logic [NUM_CH-1:0][VBITS-1:0] vals_q, vals_d;
    logic [VBITS-1:0]             time_q, time_d;
    logic [GW-1:0]                gap_q, gap_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [NUM_CH-1:0]            fire;
    logic [CW-1:0]                fire_cnt;
    logic                         accept;

    assign in_ready    = (state_q == S_IDLE) && !clear;
    assign accept      = in_ready && in_valid;
    assign busy        = (state_q != S_IDLE);
    assign time_out    = time_q;
    assign window_done = (state_q == S_ENCODE) && (time_q == T_MAX);
    assign spikes_out  = fire;
    assign spike_cnt   = cnt_q + fire_cnt;

    // A channel fires when the step reaches MAX - value, so brighter inputs fire first.
    always_comb begin
        fire     = '0;
        fire_cnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if ((state_q == S_ENCODE) && (vals_q[i] != '0) &&
                ((T_MAX - vals_q[i]) == time_q)) begin
                fire[i] = 1'b1;
            end
            fire_cnt = fire_cnt + CW'(fire[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        vals_d  = vals_q;
        time_d  = time_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = S_IDLE;
            time_d  = '0;
            gap_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_ENCODE;
                        vals_d  = values;
                        time_d  = '0;
                        cnt_d   = '0;
                    end
                end
                S_ENCODE: begin
                    cnt_d = spike_cnt;
                    if (time_q == T_MAX) begin
                        state_d = S_GAP;
                        time_d  = '0;
                        gap_d   = '0;
                    end else begin
                        time_d = time_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vals_q  <= '0;
            time_q  <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vals_q  <= vals_d;
            time_q  <= time_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder: stimulus queues accepted windows, a
// negedge monitor replays each window against an arithmetic spike-timing model.
module tb_spike_encoder;

    localparam int NUM_CH   = 8;
    localparam int VBITS    = 3;
    localparam int GAP_CYC  = 2;
    localparam int MAX      = (1 << VBITS) - 1;
    localparam int ENC_LEN  = MAX + 1;
    localparam int BUSY_LEN = ENC_LEN + GAP_CYC;
    localparam int CW       = $clog2(NUM_CH + 1);

    typedef logic [NUM_CH-1:0][VBITS-1:0] vec_t;
    typedef struct {
        vec_t vals;
        int   start;
        int   abort_e;
    } rec_t;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    vec_t              values;
    logic [NUM_CH-1:0] spikes_out;
    logic [VBITS-1:0]  time_out;
    logic              busy;
    logic              window_done;
    logic [CW-1:0]     spike_cnt;

    spike_encoder #(
        .NUM_CH (NUM_CH),
        .VBITS  (VBITS),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .values     (values),
        .spikes_out (spikes_out),
        .time_out   (time_out),
        .busy       (busy),
        .window_done(window_done),
        .spike_cnt  (spike_cnt)
    );

    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    rec_t sbq[$];
    rec_t cur;
    bit   mon_act = 0;
    int   mon_e   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: channel i spikes at step MAX - v[i]; zero channels never spike.
    function automatic logic [NUM_CH-1:0] model_spikes(input vec_t v, input int t);
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(v[i]) != 0 && MAX - int'(v[i]) == t) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic int model_count(input vec_t v, input int t);
        int n;
        n = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(v[i]) != 0 && MAX - int'(v[i]) <= t) n++;
        end
        return n;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < NUM_CH; i++) begin
            v[i] = ($urandom_range(0, 3) == 0) ? '0 : VBITS'($urandom_range(0, MAX));
        end
        return v;
    endfunction

    task automatic check_idle();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_spikes", 32'(spikes_out), 0);
        chk("idle_time", 32'(time_out), 0);
        chk("idle_cnt", 32'(spike_cnt), 0);
        chk("idle_done", 32'(window_done), 0);
        chk("idle_ready", 32'(in_ready), 32'(!clear));
    endtask

    task automatic check_busy(input rec_t r, input int e);
        chk("busy", 32'(busy), 1);
        chk("ready_busy", 32'(in_ready), 0);
        if (e < ENC_LEN) begin
            chk("enc_time", 32'(time_out), 32'(e));
            chk("enc_spikes", 32'(spikes_out), 32'(model_spikes(r.vals, e)));
            chk("enc_cnt", 32'(spike_cnt), 32'(model_count(r.vals, e)));
            chk("enc_done", 32'(window_done), 32'(e == MAX));
        end else begin
            chk("gap_time", 32'(time_out), 0);
            chk("gap_spikes", 32'(spikes_out), 0);
            chk("gap_cnt", 32'(spike_cnt), 32'(model_count(r.vals, MAX)));
            chk("gap_done", 32'(window_done), 0);
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_act) begin
                if (busy) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_window", 32'(busy), 0);
                    end else begin
                        cur     = sbq.pop_front();
                        mon_act = 1;
                        mon_e   = 0;
                        chk("start_cycle", 32'(cyc), 32'(cur.start));
                    end
                end else begin
                    if (sbq.size() != 0 && sbq[0].start <= cyc) begin
                        chk("start_busy", 32'(busy), 32'(sbq[0].abort_e != 0));
                        void'(sbq.pop_front());
                    end
                    check_idle();
                end
            end
            if (mon_act) begin
                if (mon_e >= cur.abort_e) begin
                    check_idle();
                    mon_act = 0;
                end else begin
                    check_busy(cur, mon_e);
                end
                mon_e++;
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            values = rand_vec();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_clear();
        in_valid = 1'b1;
        clear    = 1'b1;
        values   = rand_vec();
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    // kind: 0 full window, 1 clear sampled in busy cycle 'at', 2 async reset during cycle 'at'.
    // Called just after an edge with the DUT in IDLE; returns just after an edge in IDLE.
    task automatic run_window(input vec_t v, input int kind, input int at,
                              input bit hold_valid, input bit noise7);
        rec_t r;
        in_valid = 1'b1;
        values   = v;
        @(posedge clk);
        #1;
        r.vals    = v;
        r.start   = cyc;
        r.abort_e = (kind == 1) ? at + 1 : (kind == 2) ? at : BUSY_LEN;
        sbq.push_back(r);
        for (int e = 0; e < BUSY_LEN; e++) begin
            in_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
            values   = noise7 ? '1 : rand_vec();
            if (kind == 2 && e == at) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst_busy", 32'(busy), 0);
                chk("rst_spikes", 32'(spikes_out), 0);
                chk("rst_time", 32'(time_out), 0);
                chk("rst_done", 32'(window_done), 0);
                chk("rst_cnt", 32'(spike_cnt), 0);
                chk("rst_ready", 32'(in_ready), 1);
                rst_n = 1'b1;
                return;
            end
            if (kind == 1 && e == at) begin
                in_valid = 1'b1;
                clear    = 1'b1;
                @(posedge clk);
                #1;
                clear = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t v;
        vec_t ones;
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        values   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        v = '0;
        v[0] = 3'd7; v[2] = 3'd3; v[3] = 3'd3; v[4] = 3'd1; v[7] = 3'd5;
        run_window(v, 0, 0, 1'b1, 1'b0);
        run_window(v, 0, 0, 1'b1, 1'b0);
        idle(1);
        run_window('0, 0, 0, 1'b0, 1'b0);
        idle(1);
        run_window(rand_vec(), 1, 3, 1'b1, 1'b0);
        run_window(v, 0, 0, 1'b0, 1'b0);
        idle(1);
        run_window(v, 2, 5, 1'b1, 1'b0);
        idle(3);
        idle_clear();
        idle(1);
        ones = '0;
        for (int i = 0; i < NUM_CH; i++) ones[i] = 3'd1;
        run_window(ones, 0, 0, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            int r;
            int kind;
            r    = int'($urandom_range(0, 99));
            kind = (r < 15) ? 1 : (r < 25) ? 2 : 0;
            run_window(rand_vec(), kind, int'($urandom_range(0, BUSY_LEN - 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) idle_clear();
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(BUSY_LEN + 3);
        chk("queue_empty", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
